// File: rtl/dclockshare_pkg.sv
// Shared mode constants, channel FSM encoding and sizing helpers for the
// digital clock alarm path.
package dclockshare;

  localparam logic [1:0] M1_TIME       = 2'd0;
  localparam logic [1:0] M1_DATE       = 2'd1;
  localparam logic [1:0] M1_TIMER      = 2'd2;
  localparam logic [1:0] M1_ALARM      = 2'd3;

  localparam logic [1:0] M2_ALARM_HOUR = 2'd0;
  localparam logic [1:0] M2_ALARM_MIN  = 2'd1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RINGING = 2'd1;
  localparam logic [1:0] ST_SNOOZED = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  typedef struct packed {
    logic [4:0] hour;
    logic [5:0] minute;
  } alarm_time_t;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multi_alarm_ctrl_if.sv
// Control/status bundle between the clock selector path and multi_alarm_ctrl.
interface multi_alarm_ctrl_if #(
  parameter int unsigned N_ALARMS = 4
);
  import dclockshare::*;

  localparam int unsigned SEL_W = clog2_min1(N_ALARMS);

  logic                sec_tick;
  logic                increase;
  logic                set;
  logic                snooze;
  logic                toggle_en;
  logic [1:0]          mode1;
  logic [1:0]          mode2;
  logic [SEL_W-1:0]    sel_ch;
  logic [4:0]          hours;
  logic [5:0]          mins;
  logic [4:0]          alarm_h;
  logic [5:0]          alarm_m;
  logic [N_ALARMS-1:0] ch_enable;
  logic [N_ALARMS-1:0] ringing;
  logic                alarm;

  modport master (
    output sec_tick, increase, set, snooze, toggle_en, mode1, mode2, sel_ch, hours, mins,
    input  alarm_h, alarm_m, ch_enable, ringing, alarm
  );

  modport slave (
    input  sec_tick, increase, set, snooze, toggle_en, mode1, mode2, sel_ch, hours, mins,
    output alarm_h, alarm_m, ch_enable, ringing, alarm
  );

endinterface

// File: rtl/multi_alarm_ctrl_channel.sv
// One alarm channel: time registers, enable, IDLE/RINGING/SNOOZED/DONE FSM,
// countdown timer and snooze count.
module alarm_channel
  import dclockshare::*;
#(
  parameter int unsigned SNOOZE_SECS = 300,
  parameter int unsigned RING_SECS   = 60,
  parameter int unsigned MAX_SNOOZE  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sec_tick,
  input  logic        inc_hour,
  input  logic        inc_min,
  input  logic        toggle_en,
  input  logic        set,
  input  logic        snooze,
  input  logic [4:0]  hours,
  input  logic [5:0]  mins,
  output alarm_time_t alarm_time,
  output logic        enable,
  output logic        ringing
);

  localparam int unsigned TMR_MAX = (SNOOZE_SECS > RING_SECS) ? SNOOZE_SECS : RING_SECS;
  localparam int unsigned TMR_W   = clog2_min1(TMR_MAX + 1);
  localparam int unsigned CNT_W   = clog2_min1(MAX_SNOOZE + 1);

  logic [1:0]       state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  alarm_time_t      time_q, time_d;
  logic             en_q, en_d;
  logic             match_c;
  logic             clear_c;

  assign match_c = (hours == time_q.hour) && (mins == time_q.minute);
  assign clear_c = inc_hour || inc_min || (toggle_en && en_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      cnt_q   <= '0;
      time_q  <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      time_q  <= time_d;
      en_q    <= en_d;
    end
  end

  // RINGING and SNOOZED are exclusive, so one timer serves as ring and snooze timer.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    cnt_d   = cnt_q;
    time_d  = time_q;
    en_d    = en_q;

    if (inc_hour) time_d.hour   = (time_q.hour == 5'd23)   ? 5'd0 : time_q.hour + 5'd1;
    if (inc_min)  time_d.minute = (time_q.minute == 6'd59) ? 6'd0 : time_q.minute + 6'd1;
    if (toggle_en) en_d = ~en_q;

    if (clear_c) begin
      state_d = ST_IDLE;
      tmr_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (en_q && match_c) begin
            state_d = ST_RINGING;
            tmr_d   = TMR_W'(RING_SECS);
          end
        end
        ST_RINGING: begin
          if (set) begin
            state_d = ST_DONE;
          end else if (snooze) begin
            if (cnt_q < CNT_W'(MAX_SNOOZE)) begin
              state_d = ST_SNOOZED;
              cnt_d   = cnt_q + CNT_W'(1);
              tmr_d   = TMR_W'(SNOOZE_SECS);
            end else begin
              state_d = ST_DONE;
            end
          end else if (sec_tick) begin
            if (tmr_q <= TMR_W'(1)) begin
              state_d = ST_DONE;
              tmr_d   = '0;
            end else begin
              tmr_d = tmr_q - TMR_W'(1);
            end
          end
        end
        ST_SNOOZED: begin
          if (set) begin
            state_d = ST_DONE;
          end else if (sec_tick) begin
            if (tmr_q <= TMR_W'(1)) begin
              state_d = ST_RINGING;
              tmr_d   = TMR_W'(RING_SECS);
            end else begin
              tmr_d = tmr_q - TMR_W'(1);
            end
          end
        end
        ST_DONE: begin
          // Hold until the matching minute has passed so the alarm cannot re-fire.
          if (!match_c) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign alarm_time = time_q;
  assign enable     = en_q;
  assign ringing    = (state_q == ST_RINGING);

endmodule

// File: rtl/multi_alarm_ctrl.sv
// N-channel alarm controller: edit decode, channel array, sel_ch readback mux
// and combined alarm output. Optional macro ALARM_BEEP_PATTERN_EN pulses alarm.
module multi_alarm_ctrl
  import dclockshare::*;
#(
  parameter int unsigned N_ALARMS    = 4,
  parameter int unsigned SNOOZE_SECS = 300,
  parameter int unsigned RING_SECS   = 60,
  parameter int unsigned MAX_SNOOZE  = 3
) (
  input  logic               clk,
  input  logic               reset,
  multi_alarm_ctrl_if.slave  bus
);

  localparam int unsigned SEL_W = clog2_min1(N_ALARMS);

  logic                edit_mode_c;
  logic                inc_hour_c;
  logic                inc_min_c;
  logic [N_ALARMS-1:0] ch_ringing;
  logic [N_ALARMS-1:0] ch_en;
  alarm_time_t         ch_time [N_ALARMS];

  assign edit_mode_c = (bus.mode1 == M1_ALARM);
  assign inc_hour_c  = edit_mode_c && bus.increase && (bus.mode2 == M2_ALARM_HOUR);
  assign inc_min_c   = edit_mode_c && bus.increase && (bus.mode2 == M2_ALARM_MIN);

  for (genvar i = 0; i < int'(N_ALARMS); i++) begin : g_ch
    logic sel_hit_c;
    assign sel_hit_c = (bus.sel_ch == SEL_W'(i));

    alarm_channel #(
      .SNOOZE_SECS (SNOOZE_SECS),
      .RING_SECS   (RING_SECS),
      .MAX_SNOOZE  (MAX_SNOOZE)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .sec_tick   (bus.sec_tick),
      .inc_hour   (inc_hour_c && sel_hit_c),
      .inc_min    (inc_min_c && sel_hit_c),
      .toggle_en  (edit_mode_c && bus.toggle_en && sel_hit_c),
      .set        (bus.set),
      .snooze     (bus.snooze),
      .hours      (bus.hours),
      .mins       (bus.mins),
      .alarm_time (ch_time[i]),
      .enable     (ch_en[i]),
      .ringing    (ch_ringing[i])
    );
  end

  // Readback of the selected channel; out-of-range selects read 00:00.
  always_comb begin
    bus.alarm_h = '0;
    bus.alarm_m = '0;
    for (int i = 0; i < int'(N_ALARMS); i++) begin
      if (bus.sel_ch == SEL_W'(i)) begin
        bus.alarm_h = ch_time[i].hour;
        bus.alarm_m = ch_time[i].minute;
      end
    end
  end

  assign bus.ch_enable = ch_en;
  assign bus.ringing   = ch_ringing;

`ifdef ALARM_BEEP_PATTERN_EN
  logic beep_phase_q;

  // Phase restarts whenever nothing rings, so every ring episode begins high.
  always_ff @(posedge clk) begin
    if (reset || (ch_ringing == '0)) begin
      beep_phase_q <= 1'b0;
    end else if (bus.sec_tick) begin
      beep_phase_q <= ~beep_phase_q;
    end
  end

  assign bus.alarm = (|ch_ringing) && !beep_phase_q;
`else
  assign bus.alarm = |ch_ringing;
`endif

endmodule

// File: tb/tb_multi_alarm_ctrl.sv
// Directed self-checking bench for multi_alarm_ctrl (N_ALARMS=4, SNOOZE_SECS=5,
// RING_SECS=60, MAX_SNOOZE=3).
module tb_multi_alarm_ctrl;
  import dclockshare::*;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  multi_alarm_ctrl_if #(.N_ALARMS(4)) bus ();

  multi_alarm_ctrl #(
    .N_ALARMS    (4),
    .SNOOZE_SECS (5),
    .RING_SECS   (60),
    .MAX_SNOOZE  (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_inc(input int n);
    for (int k = 0; k < n; k++) begin
      bus.increase = 1'b1; tick();
      bus.increase = 1'b0; tick();
    end
  endtask

  task automatic pulse_toggle();
    bus.toggle_en = 1'b1; tick();
    bus.toggle_en = 1'b0; tick();
  endtask

  task automatic pulse_sec(input int n);
    for (int k = 0; k < n; k++) begin
      bus.sec_tick = 1'b1; tick();
      bus.sec_tick = 1'b0; tick();
    end
  endtask

  task automatic pulse_set();
    bus.set = 1'b1; tick();
    bus.set = 1'b0;
  endtask

  task automatic pulse_snooze();
    bus.snooze = 1'b1; tick();
    bus.snooze = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset         = 1'b1;
    bus.sec_tick  = 1'b0;
    bus.increase  = 1'b0;
    bus.set       = 1'b0;
    bus.snooze    = 1'b0;
    bus.toggle_en = 1'b0;
    bus.mode1     = M1_TIME;
    bus.mode2     = M2_ALARM_HOUR;
    bus.sel_ch    = 2'd0;
    bus.hours     = 5'd0;
    bus.mins      = 6'd0;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_alarm_h", 32'(bus.alarm_h), 32'd0);
    check("rst_alarm_m", 32'(bus.alarm_m), 32'd0);
    check("rst_enable",  32'(bus.ch_enable), 32'h0);
    check("rst_ringing", 32'(bus.ringing), 32'h0);
    check("rst_alarm",   32'(bus.alarm), 32'd0);

    // Hour wrap 23->0 on ch2: 25 increments land on 1
    bus.mode1  = M1_ALARM;
    bus.mode2  = M2_ALARM_HOUR;
    bus.sel_ch = 2'd2;
    pulse_inc(25);
    check("ch2_hour_wrap", 32'(bus.alarm_h), 32'd1);
    bus.mode2 = M2_ALARM_MIN;
    pulse_inc(61);
    check("ch2_min_wrap", 32'(bus.alarm_m), 32'd1);
    bus.mode2 = 2'd2;
    pulse_inc(3);
    check("ch2_mode2_other_h", 32'(bus.alarm_h), 32'd1);
    check("ch2_mode2_other_m", 32'(bus.alarm_m), 32'd1);
    for (int c = 0; c < 4; c++) begin
      if (c != 2) begin
        bus.sel_ch = 2'(c);
        #1;
        check($sformatf("ch%0d_untouched", c), 32'({bus.alarm_h, bus.alarm_m}), 32'd0);
      end
    end

    // Ch0 -> 07:30, enabled
    bus.sel_ch = 2'd0;
    bus.mode2  = M2_ALARM_HOUR;
    pulse_inc(7);
    bus.mode2 = M2_ALARM_MIN;
    pulse_inc(30);
    pulse_toggle();
    check("ch0_time", 32'({bus.alarm_h, bus.alarm_m}), 32'({5'd7, 6'd30}));
    check("ch0_enable", 32'(bus.ch_enable), 32'h1);
    bus.mode1 = M1_TIME;

    // Match seen -> ringing one cycle later
    bus.hours = 5'd7;
    bus.mins  = 6'd30;
    #1;
    check("match_same_cycle", 32'(bus.ringing), 32'h0);
    tick();
    check("match_ring", 32'(bus.ringing), 32'h1);
    check("match_alarm", 32'(bus.alarm), 32'd1);

    // Set -> DONE, no re-ring within the minute, leaves on minute change
    pulse_set();
    check("set_done", 32'(bus.ringing), 32'h0);
    tick(); tick(); tick();
    check("done_hold", 32'(bus.ringing), 32'h0);
    bus.mins = 6'd31; tick();
    bus.mins = 6'd30; tick();
    check("rering_after_idle", 32'(bus.ringing), 32'h1);

    // Three snoozes re-ring after 5 sec_ticks; fourth snooze dismisses
    for (int s = 0; s < 3; s++) begin
      pulse_snooze();
      check($sformatf("snz%0d_off", s), 32'(bus.ringing), 32'h0);
      pulse_sec(4);
      check($sformatf("snz%0d_4ticks", s), 32'(bus.ringing), 32'h0);
      pulse_sec(1);
      check($sformatf("snz%0d_rering", s), 32'(bus.ringing), 32'h1);
    end
    pulse_snooze();
    check("snz4_dismiss", 32'(bus.ringing), 32'h0);
    pulse_sec(6);
    check("snz4_stays_done", 32'(bus.ringing), 32'h0);

    // Ring timeout on the 60th sec_tick
    bus.mins = 6'd31; tick();
    bus.mins = 6'd30; tick();
    check("timeout_start", 32'(bus.ringing), 32'h1);
    pulse_sec(59);
    check("timeout_59", 32'(bus.ringing), 32'h1);
`ifdef ALARM_BEEP_PATTERN_EN
    check("beep_phase_59", 32'(bus.alarm), 32'd0);
`else
    check("steady_alarm_59", 32'(bus.alarm), 32'd1);
`endif
    pulse_sec(1);
    check("timeout_60", 32'(bus.ringing), 32'h0);
    bus.mins = 6'd31; tick();

    // Ch1 and ch3 at 06:00 ring together
    bus.mode1 = M1_ALARM;
    bus.mode2 = M2_ALARM_HOUR;
    bus.sel_ch = 2'd1; pulse_inc(6); pulse_toggle();
    bus.sel_ch = 2'd3; pulse_inc(6); pulse_toggle();
    check("ch3_hour", 32'(bus.alarm_h), 32'd6);
    bus.mode1 = M1_TIME;
    bus.hours = 5'd6;
    bus.mins  = 6'd0;
    tick();
    check("dual_ring", 32'(bus.ringing), 32'hA);
    check("dual_alarm", 32'(bus.alarm), 32'd1);
    check("dual_enable", 32'(bus.ch_enable), 32'hB);
    bus.mode1 = M1_ALARM;
    bus.toggle_en = 1'b1; tick();
    bus.toggle_en = 1'b0;
    check("disable_ch3", 32'(bus.ringing), 32'h2);
    check("disable_ch3_en", 32'(bus.ch_enable), 32'h3);
    bus.mode1 = M1_TIME;

    // Reset while ch0 is snoozed, with competing inputs active
    pulse_set();
    bus.hours = 5'd7;
    bus.mins  = 6'd30;
    tick();
    check("ch0_ring_again", 32'(bus.ringing), 32'h1);
    pulse_snooze();
    check("ch0_snoozed", 32'(bus.ringing), 32'h0);
    reset         = 1'b1;
    bus.mode1     = M1_ALARM;
    bus.increase  = 1'b1;
    bus.toggle_en = 1'b1;
    bus.sec_tick  = 1'b1;
    tick();
    reset         = 1'b0;
    bus.mode1     = M1_TIME;
    bus.increase  = 1'b0;
    bus.toggle_en = 1'b0;
    bus.sec_tick  = 1'b0;
    check("post_rst_ringing", 32'(bus.ringing), 32'h0);
    check("post_rst_alarm", 32'(bus.alarm), 32'd0);
    check("post_rst_enable", 32'(bus.ch_enable), 32'h0);
    for (int c = 0; c < 4; c++) begin
      bus.sel_ch = 2'(c);
      #1;
      check($sformatf("post_rst_time_ch%0d", c), 32'({bus.alarm_h, bus.alarm_m}), 32'd0);
    end
    pulse_sec(6);
    check("post_rst_no_rering", 32'(bus.ringing), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
